ped_button_conditioner: RTL and testbench
=========================================

// Module: ped_button_conditioner
// PURPOSE
//  Stage directly upstream of the pedestrian walk-request register.
//  - Takes the raw, asynchronous, bouncy pedestrian push-button.
//  - Synchronises it to clock and debounces it.
//  - Emits wr_sync: a single-cycle request pulse per accepted press. The walk register latches this pulse.
//  - Also exports the debounced button level, used for the status LED.
// PARAMETERS
//  SYNC_STAGES      2      flip-flop stages in the synchroniser chain; must be >= 2
//  DEBOUNCE_CYCLES  50000  consecutive stable cycles required to accept a level change (1 ms at 50 MHz); must be >= 2
//  STUCK_CYCLES     500000000  continuous-press cycles before the button is flagged stuck; used only with STUCK_DETECT_EN
// PORTS
//  clock      in   1  system clock; all flops rise-edge triggered
//  reset      in   1  asynchronous, active-low reset
//  btn_raw    in   1  raw push-button; asynchronous to clock; 1 = pressed
//  wr_sync    out  1  one-cycle pulse on each accepted press; feeds the walk register
//  btn_level  out  1  debounced button level
//  btn_stuck  out  1  button held longer than STUCK_CYCLES; tied 0 when STUCK_DETECT_EN is undefined
// BEHAVIOUR
//  Reset (reset=0, async):
//   - all sync flops, deb_cnt and outputs go to 0; state = IDLE
//   - all outputs are low during reset and on the first cycle after release
//  Synchroniser: s = btn_raw delayed by SYNC_STAGES flops; no other logic reads btn_raw.
//  FSM, one transition per clock:
//   - IDLE (level 0):
//       s=1 -> DEB_PRESS, deb_cnt <= 1.
//   - DEB_PRESS:
//       s=0 -> IDLE, deb_cnt <= 0 (bounce restarts qualification).
//       s=1 and deb_cnt == DEBOUNCE_CYCLES-1 -> PRESSED, btn_level <= 1, wr_sync <= 1 for exactly one cycle.
//       otherwise deb_cnt++.
//   - PRESSED (level 1):
//       s=0 -> DEB_RELEASE, deb_cnt <= 1.
//   - DEB_RELEASE:
//       s=1 -> PRESSED, deb_cnt <= 0.
//       s=0 and deb_cnt == DEBOUNCE_CYCLES-1 -> IDLE, btn_level <= 0.
//       otherwise deb_cnt++.
//  Latency:
//   - Stable press: wr_sync asserts SYNC_STAGES + DEBOUNCE_CYCLES edges after the first edge that samples btn_raw=1.
//   - Release: btn_level falls with the same latency.
//  wr_sync rules:
//   - Never high for two consecutive cycles.
//   - Never asserted on a release.
//   - Holding the button gives exactly one pulse; a new pulse needs a full debounced release, then a press.
//  Widths:
//   - deb_cnt width = clog2(DEBOUNCE_CYCLES).
//   - deb_cnt never exceeds DEBOUNCE_CYCLES-1; no wrap.
//  Reset mid-qualification: count is discarded; after reset release a still-held button needs a full new qualification.
//  The walk register clearing its own latch has no effect on this block (no back-pressure).
// CONFIGURATION
//  STUCK_DETECT_EN defined:
//   - A stuck_cnt counts cycles spent in PRESSED; it is cleared on any other state.
//   - At STUCK_CYCLES-1 it saturates and btn_stuck <= 1.
//   - btn_stuck clears only when the FSM returns to IDLE.
//   - While btn_stuck=1, wr_sync is forced 0.
//  STUCK_DETECT_EN undefined:
//   - No stuck_cnt is built; btn_stuck = 1'b0.
//   - Behaviour is otherwise identical.
// STRUCTURE
//  Shared header tlc_defines.vh holds:
//   - PB_IDLE/PB_DEB_PRESS/PB_PRESSED/PB_DEB_RELEASE 2-bit state encodings
//   - the clog2 constant function
//   - the default DEBOUNCE_CYCLES, shared with the other button inputs
//  Sub-module btn_synchronizer (parameter SYNC_STAGES; ports clock, reset, d, q) is the only flop chain touching btn_raw.
//  The FSM and counters stay in this module.
// TESTING (bench: SYNC_STAGES=2, DEBOUNCE_CYCLES=4, STUCK_CYCLES=20)
//  1. reset=0 with btn_raw=1 held -> wr_sync, btn_level, btn_stuck all 0; release reset -> first wr_sync exactly 6 edges later.
//  2. Clean press at edge 0, held 10 cycles -> wr_sync=1 only in the cycle after edge 6; btn_level=1 from edge 6.
//  3. Bounce 1,0,1,0 per cycle, then steady 1 -> no pulse during bounce; one wr_sync 6 edges after the last 0->1 sample.
//  4. Release glitch: in PRESSED, btn_raw=0 for 2 cycles then 1 -> btn_level stays 1; no second wr_sync.
//  5. Assert reset during DEB_PRESS (deb_cnt=2) -> outputs 0 at once; after release a held button needs a full 6-edge qualification.
//  6. STUCK_DETECT_EN, button held 40 cycles:
//     -> btn_stuck rises 20 cycles after entering PRESSED;
//     -> release and re-press give no wr_sync until IDLE is reached, which clears btn_stuck;
//     -> next press pulses normally.

Source files
------------

// File: rtl/ped_button_conditioner_pkg.sv
// Shared definitions for the pedestrian button conditioner: FSM state encoding,
// the default debounce length shared with the other button inputs, and a clog2 helper.
package ped_button_conditioner_pkg;

   typedef enum logic [1:0] {
      PB_IDLE        = 2'd0,
      PB_DEB_PRESS   = 2'd1,
      PB_PRESSED     = 2'd2,
      PB_DEB_RELEASE = 2'd3
   } pb_state_e;

   localparam int unsigned PB_DEBOUNCE_CYCLES_DEFAULT = 50000;

   function automatic int unsigned clog2(input int unsigned value);
      int unsigned result;
      result = 0;
      for (int unsigned i = 0; i < 32; i++) begin
         if ((64'(1) << i) < 64'(value)) result = i + 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/ped_button_conditioner_btn_synchronizer.sv
// Multi-flop synchroniser for the asynchronous push-button input; the only
// flop chain that samples the raw button.
module btn_synchronizer #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic clock,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic [SYNC_STAGES-1:0] sync_d;

   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], d};
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) sync_q <= '0;
      else        sync_q <= sync_d;
   end

   assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/ped_button_conditioner.sv
// Pedestrian push-button conditioner: synchronise, debounce, one pulse per accepted press.
// Optional stuck-button detection is built when STUCK_DETECT_EN is defined.
module ped_button_conditioner
   import ped_button_conditioner_pkg::*;
#(
   parameter int unsigned SYNC_STAGES     = 2,
   parameter int unsigned DEBOUNCE_CYCLES = PB_DEBOUNCE_CYCLES_DEFAULT,
   parameter int unsigned STUCK_CYCLES    = 500000000
) (
   input  logic clock,
   input  logic reset,
   input  logic btn_raw,
   output logic wr_sync,
   output logic btn_level,
   output logic btn_stuck
);

   localparam int unsigned     CNT_W    = clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   if (SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 2 || STUCK_CYCLES < 2) begin : g_param_check
      $error("ped_button_conditioner: SYNC_STAGES, DEBOUNCE_CYCLES and STUCK_CYCLES must be >= 2");
   end

   logic             s;
   pb_state_e        state_q, state_d;
   logic [CNT_W-1:0] deb_cnt_q, deb_cnt_d;
   logic             wr_sync_q, wr_sync_d;
   logic             btn_level_q, btn_level_d;
   logic             stuck_block;

   btn_synchronizer #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clock (clock),
      .reset (reset),
      .d     (btn_raw),
      .q     (s)
   );

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q     <= PB_IDLE;
         deb_cnt_q   <= '0;
         wr_sync_q   <= 1'b0;
         btn_level_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         deb_cnt_q   <= deb_cnt_d;
         wr_sync_q   <= wr_sync_d;
         btn_level_q <= btn_level_d;
      end
   end

   // A disagreeing sample during qualification drops back to the settled state with a cleared count.
   always_comb begin
      state_d   = state_q;
      deb_cnt_d = deb_cnt_q;
      unique case (state_q)
         PB_IDLE: begin
            if (s) begin
               state_d   = PB_DEB_PRESS;
               deb_cnt_d = CNT_W'(1);
            end
         end
         PB_DEB_PRESS: begin
            if (!s) begin
               state_d   = PB_IDLE;
               deb_cnt_d = '0;
            end else if (deb_cnt_q == CNT_LAST) begin
               state_d   = PB_PRESSED;
               deb_cnt_d = '0;
            end else begin
               deb_cnt_d = deb_cnt_q + CNT_W'(1);
            end
         end
         PB_PRESSED: begin
            if (!s) begin
               state_d   = PB_DEB_RELEASE;
               deb_cnt_d = CNT_W'(1);
            end
         end
         PB_DEB_RELEASE: begin
            if (s) begin
               state_d   = PB_PRESSED;
               deb_cnt_d = '0;
            end else if (deb_cnt_q == CNT_LAST) begin
               state_d   = PB_IDLE;
               deb_cnt_d = '0;
            end else begin
               deb_cnt_d = deb_cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d   = PB_IDLE;
            deb_cnt_d = '0;
         end
      endcase
   end

   always_comb begin
      btn_level_d = (state_d == PB_PRESSED) || (state_d == PB_DEB_RELEASE);
      wr_sync_d   = (state_q == PB_DEB_PRESS) && (state_d == PB_PRESSED) && !stuck_block;
   end

   assign wr_sync   = wr_sync_q;
   assign btn_level = btn_level_q;

`ifdef STUCK_DETECT_EN
   localparam int unsigned       STUCK_W    = clog2(STUCK_CYCLES);
   localparam logic [STUCK_W-1:0] STUCK_LAST = STUCK_W'(STUCK_CYCLES - 1);

   logic [STUCK_W-1:0] stuck_cnt_q, stuck_cnt_d;
   logic               btn_stuck_q, btn_stuck_d;

   // The flag survives release glitches; only a fully debounced return to IDLE clears it.
   always_comb begin
      stuck_cnt_d = '0;
      btn_stuck_d = btn_stuck_q;
      if (state_q == PB_PRESSED) begin
         if (stuck_cnt_q == STUCK_LAST) begin
            stuck_cnt_d = stuck_cnt_q;
            btn_stuck_d = 1'b1;
         end else begin
            stuck_cnt_d = stuck_cnt_q + STUCK_W'(1);
         end
      end
      if (state_d == PB_IDLE) btn_stuck_d = 1'b0;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         stuck_cnt_q <= '0;
         btn_stuck_q <= 1'b0;
      end else begin
         stuck_cnt_q <= stuck_cnt_d;
         btn_stuck_q <= btn_stuck_d;
      end
   end

   assign stuck_block = btn_stuck_q;
   assign btn_stuck   = btn_stuck_q;
`else
   assign stuck_block = 1'b0;
   assign btn_stuck   = 1'b0;
`endif

endmodule

// File: tb/tb_ped_button_conditioner.sv
// Scoreboard bench for ped_button_conditioner: a run-length reference model pushes
// expected outputs each edge; a negedge monitor pops and compares.
module tb_ped_button_conditioner;

   localparam int unsigned SYNC  = 2;
   localparam int unsigned DEB   = 4;
   localparam int unsigned STUCK = 20;

   typedef struct packed {
      logic wr;
      logic lvl;
      logic stk;
   } exp_t;

   logic clk;
   logic rst_n;
   logic btn_raw;
   logic wr_sync;
   logic btn_level;
   logic btn_stuck;

   int checks = 0;
   int errors = 0;

   exp_t exp_q[$];
   bit   raw_hist[$];
   bit   m_level;
   int   m_run;
   int   m_scnt;
   bit   m_stuck;
   bit   prev_wr;

   ped_button_conditioner #(
      .SYNC_STAGES     (SYNC),
      .DEBOUNCE_CYCLES (DEB),
      .STUCK_CYCLES    (STUCK)
   ) dut (
      .clock     (clk),
      .reset     (rst_n),
      .btn_raw   (btn_raw),
      .wr_sync   (wr_sync),
      .btn_level (btn_level),
      .btn_stuck (btn_stuck)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference model: level flips once DEB consecutive synchronised samples disagree with it.
   always @(posedge clk) begin
      exp_t e;
      bit   s;
      bit   rise;
      bit   pressed_now;
      e = '0;
      if (!rst_n) begin
         m_level  = 1'b0;
         m_run    = 0;
         m_scnt   = 0;
         m_stuck  = 1'b0;
         raw_hist = {};
         for (int i = 0; i < int'(SYNC); i++) raw_hist.push_back(1'b0);
      end else begin
         raw_hist.push_back(btn_raw);
         s           = raw_hist.pop_front();
         pressed_now = m_level && (m_run == 0);
         rise        = 1'b0;
         if (s != m_level) begin
            m_run++;
            if (m_run == int'(DEB)) begin
               m_level = s;
               m_run   = 0;
               rise    = s;
            end
         end else begin
            m_run = 0;
         end
         e.wr = rise && !m_stuck;
`ifdef STUCK_DETECT_EN
         if (pressed_now) begin
            if (m_scnt == int'(STUCK) - 1) m_stuck = 1'b1;
            else                           m_scnt++;
         end else begin
            m_scnt = 0;
         end
         if (!m_level && m_run == 0) m_stuck = 1'b0;
`else
         if (pressed_now) m_scnt++;
`endif
         e.lvl = m_level;
         e.stk = m_stuck;
      end
      exp_q.push_back(e);
   end

   always @(negedge clk) begin
      exp_t e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         if (!rst_n) e = '0;
         checks++;
         if (wr_sync !== e.wr) begin
            errors++;
            $display("FAIL wr_sync t=%0t got %b want %b", $time, wr_sync, e.wr);
         end
         checks++;
         if (btn_level !== e.lvl) begin
            errors++;
            $display("FAIL btn_level t=%0t got %b want %b", $time, btn_level, e.lvl);
         end
         checks++;
         if (btn_stuck !== e.stk) begin
            errors++;
            $display("FAIL btn_stuck t=%0t got %b want %b", $time, btn_stuck, e.stk);
         end
         checks++;
         if (prev_wr && wr_sync) begin
            errors++;
            $display("FAIL wr_sync_double t=%0t got 11 want not 11", $time);
         end
         prev_wr = wr_sync;
      end
   end

   task automatic drive(input bit v, input int n);
      btn_raw = v;
      repeat (n) begin
         @(posedge clk);
         #3;
      end
   endtask

   // Button held; the first edge after reset release samples it, pulse due on edge SYNC+DEB.
   task automatic latency_check(input string name);
      int seen;
      seen = 0;
      for (int k = 1; k <= 20; k++) begin
         @(posedge clk);
         #1;
         if (wr_sync === 1'b1 && seen == 0) seen = k;
         #2;
      end
      checks++;
      if (seen != int'(SYNC + DEB)) begin
         errors++;
         $display("FAIL %s got edge %0d want edge %0d", name, seen, SYNC + DEB);
      end
   endtask

   initial begin
      prev_wr = 1'b0;
      rst_n   = 1'b0;
      btn_raw = 1'b1;
      repeat (3) @(posedge clk);
      #3;
      rst_n = 1'b1;
      latency_check("reset_release_latency");

      drive(1'b0, 12);
      drive(1'b1, 12);

      drive(1'b0, 12);
      drive(1'b1, 1);
      drive(1'b0, 1);
      drive(1'b1, 1);
      drive(1'b0, 1);
      drive(1'b1, 12);

      drive(1'b0, 2);
      drive(1'b1, 10);

      drive(1'b0, 12);
      drive(1'b1, 4);
      rst_n = 1'b0;
      drive(1'b1, 2);
      rst_n = 1'b1;
      latency_check("reset_mid_qual_latency");

      drive(1'b0, 12);
      drive(1'b1, 40);
      drive(1'b0, 2);
      drive(1'b1, 5);
      drive(1'b0, 12);
      drive(1'b1, 12);
      drive(1'b0, 12);

      for (int i = 0; i < 150; i++) begin
         if ($urandom_range(0, 29) == 0) begin
            rst_n = 1'b0;
            drive(btn_raw, 1);
            rst_n = 1'b1;
         end
         drive(1'($urandom_range(0, 1)), int'($urandom_range(1, 7)));
      end

      drive(1'b0, 12);
      @(negedge clk);
      @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
